// File: rtl/uart_reg_ctrl.sv
// uart_reg_ctrl: byte-command sequencer between the UART core and a register bank.
// Command bit7 selects write (a data byte follows) or read; the low bits carry the address.
module uart_reg_ctrl #(
  parameter int         ADDR_W   = 7,
  parameter int         TIMEOUT  = 5000000,
  parameter logic [7:0] ACK_BYTE = 8'h55,
  parameter logic [7:0] NAK_BYTE = 8'hEE
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              recieved,
  input  logic [7:0]        data_rx,
  input  logic              busy_tx,
  output logic              transmit,
  output logic [7:0]        data_tx,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  localparam int               CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, GET_DATA, WR, RD, TX_START, TX_WAIT} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [7:0]        data_tx_d, reg_wdata_d;
  logic [ADDR_W-1:0] reg_addr_d;
  logic              tx_first, tx_first_d;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= IDLE;
      cnt       <= '0;
      data_tx   <= '0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      tx_first  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      data_tx   <= data_tx_d;
      reg_addr  <= reg_addr_d;
      reg_wdata <= reg_wdata_d;
      tx_first  <= tx_first_d;
      busy      <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    data_tx_d   = data_tx;
    reg_addr_d  = reg_addr;
    reg_wdata_d = reg_wdata;
    tx_first_d  = 1'b0;
    transmit    = 1'b0;
    reg_we      = 1'b0;
    case (state)
      IDLE: begin
        if (recieved) begin
          reg_addr_d = data_rx[ADDR_W-1:0];
          if (data_rx[7]) begin
            state_d = GET_DATA;
            cnt_d   = '0;
          end else begin
            state_d = RD;
          end
        end
      end
      GET_DATA: begin
        // A byte landing in the final allowed cycle still beats the timeout.
        if (recieved) begin
          reg_wdata_d = data_rx;
          state_d     = WR;
        end else if (cnt == CNT_MAX) begin
          data_tx_d = NAK_BYTE;
          state_d   = TX_START;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      WR: begin
        reg_we    = 1'b1;
        data_tx_d = ACK_BYTE;
        state_d   = TX_START;
      end
      RD: begin
        data_tx_d = reg_rdata;
        state_d   = TX_START;
      end
      TX_START: begin
        if (!busy_tx) begin
          transmit   = 1'b1;
          tx_first_d = 1'b1;
          state_d    = TX_WAIT;
        end
      end
      TX_WAIT: begin
        // busy_tx lags the transmit pulse by a cycle, so ignore it right after the pulse.
        if (!tx_first && !busy_tx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Bench for uart_reg_ctrl: vector table, directed corner sequences and random
// transactions checked against a transaction-level model of the command protocol.
`timescale 1ns/1ps
module tb_uart_reg_ctrl;
  localparam int         TIMEOUT = 16;
  localparam logic [7:0] ACK     = 8'h55;
  localparam logic [7:0] NAK     = 8'hEE;

  logic       clk = 1'b0, nRst = 1'b1, recieved = 1'b0;
  logic       busy_auto = 1'b0, busy_force = 1'b0, busy_tx;
  logic [7:0] data_rx = 8'h00;
  logic       transmit, reg_we, busy;
  logic [7:0] data_tx, reg_wdata, reg_rdata;
  logic [6:0] reg_addr;

  assign busy_tx = busy_auto | busy_force;

  uart_reg_ctrl #(.ADDR_W(7), .TIMEOUT(TIMEOUT), .ACK_BYTE(ACK), .NAK_BYTE(NAK)) dut (
    .clk(clk), .nRst(nRst), .recieved(recieved), .data_rx(data_rx), .busy_tx(busy_tx),
    .transmit(transmit), .data_tx(data_tx), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_we(reg_we), .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [6:0] a);
    return (a == 7'd8) ? 8'h3C : ({1'b0, a} ^ 8'h5A);
  endfunction

  // Register bank the DUT talks to; combinational read, write on the strobe.
  logic [7:0] bank [128];
  assign reg_rdata = bank[reg_addr];
  initial begin
    for (int a = 0; a < 128; a++) bank[a] = init_val(7'(a));
    forever begin
      @(posedge clk);
      if (reg_we) bank[reg_addr] = reg_wdata;
    end
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef struct { int cyc; logic [7:0] val; logic [6:0] addr; } ev_t;
  ev_t txq[$];
  ev_t weq[$];
  initial forever begin
    @(negedge clk);
    if (transmit) txq.push_back('{cyc, data_tx, 7'd0});
    if (reg_we)   weq.push_back('{cyc, reg_wdata, reg_addr});
  end

  // Transmitter stand-in: busy rises the cycle after the pulse and lasts a few cycles.
  initial forever begin
    @(negedge clk);
    if (transmit) begin
      @(posedge clk); #1 busy_auto = 1'b1;
      repeat ($urandom_range(8, 2)) @(posedge clk);
      #1 busy_auto = 1'b0;
    end
  end

  int nchk = 0, npass = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, output int at);
    at = cyc; recieved = 1'b1; data_rx = b;
    @(posedge clk); #1;
    recieved = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!(txq.size() > 0 && !busy && !busy_tx) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done"}, 32'(n < 300), 1);
    step(3);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_transmit"}, transmit, 0);
    chk({nm, "_reg_we"}, reg_we, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_data_tx"}, data_tx, 0);
    chk({nm, "_reg_addr"}, reg_addr, 0);
    chk({nm, "_reg_wdata"}, reg_wdata, 0);
  endtask

  // Reference model: the data byte may follow the command by at most TIMEOUT cycles;
  // latency is counted from the command byte's cycle to the transmit pulse.
  logic [7:0] ref_mem [128];
  task automatic model(input logic [7:0] cmd, input bit has_data, input logic [7:0] data,
                       input int gap, output logic [7:0] resp, output int lat, output bit we);
    if (!cmd[7]) begin
      resp = ref_mem[cmd[6:0]]; lat = 2; we = 1'b0;
    end else if (has_data && gap < TIMEOUT) begin
      ref_mem[cmd[6:0]] = data; resp = ACK; lat = gap + 3; we = 1'b1;
    end else begin
      resp = NAK; lat = TIMEOUT + 1; we = 1'b0;
    end
  endtask

  int cmd_cyc;
  task automatic run_txn(input logic [7:0] cmd, input bit has_data, input logic [7:0] data,
                         input int gap);
    int t;
    txq.delete(); weq.delete();
    send(cmd, cmd_cyc);
    if (has_data) begin
      step(gap);
      send(data, t);
    end
    wait_done("txn");
  endtask

  task automatic check_txn(input string nm, input logic [7:0] cmd, input logic [7:0] data,
                           input logic [7:0] resp, input int lat, input bit we);
    chk({nm, "_ntx"}, txq.size(), 1);
    if (txq.size() > 0) begin
      chk({nm, "_resp"}, txq[0].val, resp);
      chk({nm, "_lat"}, txq[0].cyc - cmd_cyc, lat);
    end
    chk({nm, "_nwe"}, weq.size(), 32'(we));
    if (we && weq.size() > 0) begin
      chk({nm, "_we_addr"}, weq[0].addr, cmd[6:0]);
      chk({nm, "_we_data"}, weq[0].val, data);
    end
    chk({nm, "_idle"}, busy, 0);
  endtask

  typedef struct {
    logic [7:0] cmd; bit has_data; logic [7:0] data; int gap;
    logic [7:0] resp; int lat; bit we;
  } vec_t;
  vec_t tbl [12];

  initial begin
    logic [7:0] resp, cmd, d;
    int lat, t, n, rel, bad_tx, bad_dt, kind;
    bit we, has;

    tbl[0]  = '{8'h83, 1'b1, 8'hA5, 0,  8'h55, 3,  1'b1};
    tbl[1]  = '{8'h08, 1'b0, 8'h00, 0,  8'h3C, 2,  1'b0};
    tbl[2]  = '{8'h03, 1'b0, 8'h00, 0,  8'hA5, 2,  1'b0};
    tbl[3]  = '{8'h81, 1'b0, 8'h00, 0,  8'hEE, 17, 1'b0};
    tbl[4]  = '{8'h01, 1'b0, 8'h00, 0,  8'h5B, 2,  1'b0};
    tbl[5]  = '{8'h8A, 1'b1, 8'h77, 15, 8'h55, 18, 1'b1};
    tbl[6]  = '{8'h0A, 1'b0, 8'h00, 0,  8'h77, 2,  1'b0};
    tbl[7]  = '{8'h8B, 1'b1, 8'h99, 16, 8'hEE, 17, 1'b0};
    tbl[8]  = '{8'h0B, 1'b0, 8'h00, 0,  8'h51, 2,  1'b0};
    tbl[9]  = '{8'hFF, 1'b1, 8'h00, 3,  8'h55, 6,  1'b1};
    tbl[10] = '{8'h7F, 1'b0, 8'h00, 0,  8'h00, 2,  1'b0};
    tbl[11] = '{8'h00, 1'b0, 8'h00, 0,  8'h5A, 2,  1'b0};
    for (int a = 0; a < 128; a++) ref_mem[a] = init_val(7'(a));

    #2 nRst = 1'b0;
    #1 chk_zero("reset");
    step(3);
    nRst = 1'b1;
    step(2);

    for (int i = 0; i < 12; i++) begin
      model(tbl[i].cmd, tbl[i].has_data, tbl[i].data, tbl[i].gap, resp, lat, we);
      run_txn(tbl[i].cmd, tbl[i].has_data, tbl[i].data, tbl[i].gap);
      check_txn($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].data, tbl[i].resp, tbl[i].lat, tbl[i].we);
    end

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(2, 0);
      cmd  = {kind != 0, 7'($urandom)};
      d    = 8'($urandom);
      has  = (kind == 1);
      n    = $urandom_range(TIMEOUT - 1, 0);
      model(cmd, has, d, n, resp, lat, we);
      run_txn(cmd, has, d, n);
      check_txn($sformatf("rnd%0d", i), cmd, d, resp, lat, we);
    end

    // Backpressure: transmitter busy while the response waits in TX_START.
    txq.delete(); weq.delete();
    busy_force = 1'b1;
    send(8'h08, cmd_cyc);
    step(1);
    bad_tx = 0; bad_dt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (transmit) bad_tx++;
      if (data_tx !== ref_mem[8]) bad_dt++;
    end
    @(posedge clk); #1;
    rel = cyc;
    busy_force = 1'b0;
    chk("bp_no_tx", bad_tx, 0);
    chk("bp_dtx_stable", bad_dt, 0);
    step(1);
    send(8'h08, t);
    send(8'h85, t);
    wait_done("bp");
    chk("bp_ntx", txq.size(), 1);
    if (txq.size() > 0) begin
      chk("bp_resp", txq[0].val, ref_mem[8]);
      chk("bp_release_cyc", txq[0].cyc, rel);
    end
    chk("bp_nwe", weq.size(), 0);
    chk("bp_idle", busy, 0);

    // Give reg_wdata/data_tx nonzero contents before the reset checks.
    model(8'h85, 1'b1, 8'hC3, 2, resp, lat, we);
    run_txn(8'h85, 1'b1, 8'hC3, 2);
    check_txn("prewr", 8'h85, 8'hC3, resp, lat, we);

    // Reset while waiting for the data byte.
    txq.delete(); weq.delete();
    send(8'h81, cmd_cyc);
    step(3);
    nRst = 1'b0;
    #1 chk_zero("rst_getdata");
    step(2);
    nRst = 1'b1;
    step(TIMEOUT + 5);
    chk("rst_getdata_no_tx", txq.size(), 0);
    chk("rst_getdata_no_we", weq.size(), 0);
    chk("rst_getdata_idle", busy, 0);
    model(8'h00, 1'b0, 8'h00, 0, resp, lat, we);
    run_txn(8'h00, 1'b0, 8'h00, 0);
    check_txn("after_rst1", 8'h00, 8'h00, resp, lat, we);

    // Reset while waiting for the transmitter to finish.
    txq.delete(); weq.delete();
    send(8'h05, cmd_cyc);
    n = 0;
    while (txq.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_txwait_pulse", 32'(n < 20), 1);
    if (txq.size() > 0) chk("rst_txwait_resp", txq[0].val, ref_mem[5]);
    @(posedge clk); #1;
    step(1);
    nRst = 1'b0;
    #1 chk_zero("rst_txwait");
    step(2);
    nRst = 1'b1;
    n = 0;
    while (busy_tx && n < 50) begin
      step(1);
      n++;
    end
    step(2);
    chk("rst_txwait_ntx", txq.size(), 1);
    chk("rst_txwait_idle", busy, 0);
    model(8'h00, 1'b0, 8'h00, 0, resp, lat, we);
    run_txn(8'h00, 1'b0, 8'h00, 0);
    check_txn("after_rst2", 8'h00, 8'h00, resp, lat, we);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", npass, nchk);
    $fatal(1);
  end

endmodule

// File: doc/uart_reg_ctrl.md
Name: uart_reg_ctrl

Overview:
Command sequencer between the UART core and a small register bank. It parses byte commands from the UART receiver, performs register reads and writes, and drives the UART transmitter to return a response byte. It sits in the top level alongside the uart instance and owns its transmit/data_tx inputs.

Parameters:
ADDR_W, 7, register address width; the command byte carries the address in bits [6:0].
TIMEOUT, 5000000, clock cycles allowed between the command byte and the data byte (100 ms at 50 MHz).
ACK_BYTE, 8'h55, response byte sent after a write.
NAK_BYTE, 8'hEE, response byte sent after a data-byte timeout.

Ports:
clk  in  1  system clock, 50 MHz
nRst  in  1  asynchronous active-low reset
recieved  in  1  one-cycle pulse from the UART receiver: data_rx valid
data_rx  in  8  received byte
busy_tx  in  1  UART transmitter busy
transmit  out  1  one-cycle pulse: start transmitting data_tx
data_tx  out  8  byte to transmit; held stable while transmit is high and while busy_tx is high
reg_addr  out  ADDR_W  register address
reg_wdata  out  8  register write data
reg_we  out  1  one-cycle register write strobe
reg_rdata  in  8  register read data; combinational from reg_addr
busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset, asynchronous on nRst low: state IDLE; transmit, reg_we, and busy are 0; data_tx, reg_addr, reg_wdata, and the timeout counter are 0. Reset mid-transaction abandons the transaction and sends no response.
- Command byte format:
  - bit7=1: write; the next received byte is the data.
  - bit7=0: read.
  - bits[6:0] give the address.
- IDLE:
  - On recieved, latch data_rx[6:0] into reg_addr.
  - If bit7=1: go to GET_DATA and clear the timeout counter.
  - If bit7=0: go to RD.
- GET_DATA:
  - On recieved: latch the byte into reg_wdata and go to WR.
  - Otherwise increment the counter. When it reaches TIMEOUT-1, load data_tx=NAK_BYTE and go to TX_START.
  - If recieved arrives in the same cycle the counter reaches TIMEOUT-1, the byte wins: go to WR.
- WR: reg_we=1 for exactly this one cycle with the latched reg_addr/reg_wdata. Load data_tx=ACK_BYTE and go to TX_START.
- RD: one cycle for reg_addr to settle. Load data_tx=reg_rdata sampled at the end of this cycle, then go to TX_START.
- TX_START:
  - If busy_tx=0: pulse transmit for one cycle and go to TX_WAIT.
  - Else remain in TX_START; transmit stays 0.
- TX_WAIT:
  - The cycle after the pulse is ignored, to allow busy_tx to rise.
  - From then on, go to IDLE when busy_tx=0.
- recieved pulses in any state other than IDLE and GET_DATA are discarded. No queuing.
- Latency, recieved pulse of the last command byte to transmit pulse with busy_tx low:
  - write: 2 cycles (GET_DATA→WR→TX_START).
  - read: 2 cycles (IDLE→RD→TX_START).
- reg_addr and reg_wdata hold their last values in IDLE.
- The timeout counter is wide enough for TIMEOUT-1: $clog2(TIMEOUT) bits. It saturates and never wraps.
- busy is registered from the state: high in every state except IDLE.

Test Plan:
- Write: recieved 8'h83 then 8'hA5 → one reg_we pulse with reg_addr=3 and reg_wdata=8'hA5; then transmit with data_tx=8'h55; state returns to IDLE after busy_tx falls.
- Read: reg_rdata model returns 8'h3C for address 8. recieved 8'h08 → no reg_we; transmit pulse exactly 2 cycles after recieved, with data_tx=8'h3C.
- Timeout: recieved 8'h81 and no further byte; use TIMEOUT=16 → transmit with data_tx=8'hEE 16 cycles after entry to GET_DATA; no reg_we at any point.
- Backpressure:
  - busy_tx held high for 100 cycles during TX_START → no transmit until busy_tx falls; data_tx stable throughout.
  - Extra recieved bytes during TX_WAIT are ignored and produce no second response.
- Boundary: data byte arrives in the same cycle the counter reaches TIMEOUT-1 → write performed and ACK sent, no NAK.
- Reset mid-operation: assert nRst low in GET_DATA and in TX_WAIT → all outputs 0 immediately; a subsequent read command 8'h00 behaves normally.
